// File: rtl/snail_pkg.sv
// Shared definitions for the 1101 sync-pattern link (transmitter and detector).
package snail_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1101;

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/snail_piso.sv
// Parallel-in serial-out shift register, MSB first; zeros fill in behind, so dout idles low.
// Load wins over shift; dout is the register MSB, available the cycle after load.
module snail_piso #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[W-1];

endmodule

// File: rtl/snail_pattern_tx.sv
// Serial frame transmitter: sync pattern + payload (+ even parity with SNAIL_TX_PARITY_EN), MSB first;
// first bit one cycle after accept; ready only in IDLE, start while busy is dropped.
module snail_pattern_tx
  import snail_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEFAULT,
  parameter int                GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              a,
  output logic              frame,
  output logic              done
);

`ifdef SNAIL_TX_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int     FW      = SYNC_W + DATA_W + PAR_W;
  localparam int     CW      = $clog2(max3(SYNC_W, DATA_W, GAP) + 1);
  localparam state_e POST_ST = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            load;
  logic            last;
  logic [FW-1:0]   load_vec;

`ifdef SNAIL_TX_PARITY_EN
  assign load_vec = {SYNC, data, ^data};
`else
  assign load_vec = {SYNC, data};
`endif

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SYNC;
          cnt_d   = CW'(SYNC_W);
        end
      end
      ST_SYNC: begin
        if (last) begin
          state_d = ST_DATA;
          cnt_d   = CW'(DATA_W);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (last) begin
`ifdef SNAIL_TX_PARITY_EN
          state_d = ST_PAR;
          cnt_d   = '0;
`else
          done_d  = 1'b1;
          state_d = POST_ST;
          cnt_d   = CW'(GAP);
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PAR: begin
        done_d  = 1'b1;
        state_d = POST_ST;
        cnt_d   = CW'(GAP);
      end
      ST_GAP: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    frame = (state_q == ST_SYNC) || (state_q == ST_DATA) || (state_q == ST_PAR);
    done  = done_q;
  end

  // The shifter runs only while framing, so its drained zeros keep a low in IDLE/GAP.
  snail_piso #(
    .W(FW)
  ) u_piso (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(frame),
    .din  (load_vec),
    .dout (a)
  );

endmodule

// File: tb/tb_snail_pattern_tx.sv
// Bench for snail_pattern_tx at default parameters; follows SNAIL_TX_PARITY_EN when defined.
module tb_snail_pattern_tx;

  localparam int DW = 8;
  localparam int GP = 2;
`ifdef SNAIL_TX_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int FL = 4 + DW + PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] data;
  logic          ready;
  logic          a;
  logic          frame;
  logic          done;

  snail_pattern_tx dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .data (data),
    .ready(ready),
    .a    (a),
    .frame(frame),
    .done (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [FL-1:0] sb[$];

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FL-1:0] exp_frame(input logic [DW-1:0] d);
    logic [3:0] s;
    s = 4'b1101;
`ifdef SNAIL_TX_PARITY_EN
    return {s, d, ^d};
`else
    return {s, d};
`endif
  endfunction

  // Monitor: rebuild each frame from a while frame is high, then score it.
  logic [FL-1:0] cur = '0;
  int            len = 0;
  logic          prev_frame = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      len        = 0;
      prev_frame = 1'b0;
      cur        = '0;
    end else begin
      if (done || (prev_frame && !frame))
        check_eq("done_pulse", done, prev_frame && !frame);
      if (frame) begin
        cur = {cur[FL-2:0], a};
        len++;
      end else if (len > 0) begin
        check_eq("frame_len", len, FL);
        check_eq("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) check_eq("frame_bits", cur, sb.pop_front());
        len = 0;
      end
      prev_frame = frame;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", ready, 1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    wait_ready();
    start = 1'b1;
    data  = d;
    sb.push_back(exp_frame(d));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle-exact check; cycle k is the k-th negedge after the accepting edge.
  task automatic tx_timed(input logic [DW-1:0] d, input bit poke);
    logic [FL-1:0] f;
    f = exp_frame(d);
    wait_ready();
    start = 1'b1;
    data  = d;
    sb.push_back(f);
    for (int k = 1; k <= FL + GP + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      check_eq("a", a, (k <= FL) ? 32'(f[FL-k]) : 32'd0);
      check_eq("frame", frame, k <= FL);
      check_eq("done", done, k == FL + 1);
      check_eq("ready", ready, k >= FL + GP + 1);
      if (poke && k == 4) begin
        start = 1'b1;
        data  = 8'hFF;
      end
      if (poke && k == 5) start = 1'b0;
    end
  endtask

  int acc1;
  int acc2;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    data  = '0;
    #1;
    check_eq("rst_a", a, 0);
    check_eq("rst_frame", frame, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready", ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    tx_timed(8'hA5, 1'b0);
    tx_timed(8'h07, 1'b0);
    tx_timed(8'hC3, 1'b1);

    // Asynchronous reset in the middle of a frame.
    send(8'hA5);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_a", a, 0);
    check_eq("arst_frame", frame, 0);
    check_eq("arst_ready", ready, 1);
    check_eq("arst_done", done, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'h3C);

    // start held high across two frames; data changes right after the first accept.
    wait_ready();
    start = 1'b1;
    data  = 8'h81;
    sb.push_back(exp_frame(8'h81));
    @(negedge clk);
    acc1 = cyc;
    data = 8'h18;
    wait_ready();
    sb.push_back(exp_frame(8'h18));
    @(negedge clk);
    acc2  = cyc;
    start = 1'b0;
    check_eq("b2b_spacing", acc2 - acc1, FL + GP + 1);
    check_eq("b2b_first_bit", a, 1);
    check_eq("b2b_frame", frame, 1);

    send(8'h00);
    send(8'hFF);
    wait_ready();
    @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("idle_frame", frame, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
